// File: rtl/ifu_prefetch_pkg.sv
// Shared constants and FSM encoding for the instruction prefetch unit.
// Imported by the top level and by the testbench.
package ifu_prefetch_pkg;

  localparam int          XLEN_DEF     = 64;
  localparam int          ILEN_DEF     = 32;
  localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_e;

endpackage

// File: rtl/ifu_prefetch_sync_fifo.sv
// Synchronous FIFO with flush; the head reads as zero while empty so
// downstream outputs are clean without resetting the storage array.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !clr) r_mem[r_wr_ptr] <= push_data;
  end

  assign empty    = (r_count == '0);
  assign full     = (r_count == CW'(DEPTH));
  assign count    = r_count;
  assign pop_data = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: pipelined in-order memory reads feeding a
// prefetch FIFO in front of decode, with redirect flush and stop-on-error.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int               XLEN            = XLEN_DEF,
  parameter int               ILEN            = ILEN_DEF,
  parameter int               FIFO_DEPTH      = 4,
  parameter int               MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0]  RESET_PC        = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  input  logic            mem_resp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_err,
  output logic            busy,
  output state_e          dbg_state
);

  localparam int IW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int CRW = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1) + 1;
  localparam int EW  = 1 + XLEN + ILEN;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [XLEN-1:0]   r_fetch_pc;
  logic [IW-1:0]     r_inflight;
  logic [IW-1:0]     r_discard;

  logic              w_req_hs;
  logic              w_resp_keep;
  logic [CRW-1:0]    w_credit;
  logic [XLEN/2-1:0] w_half;

  logic              w_fifo_push;
  logic              w_fifo_pop;
  logic [EW-1:0]     w_fifo_wdata;
  logic [EW-1:0]     w_fifo_rdata;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [FCW-1:0]    w_fifo_count;

  logic [XLEN-1:0]   w_pcq_head;
  logic              w_pcq_full;
  logic              w_pcq_empty;
  logic [IW-1:0]     w_pcq_count;

  // Handshakes: a request transfers on mem_req_valid && mem_req_ready and the
  // address holds while valid waits for ready; responses return in request
  // order and are always accepted; an instruction transfers on
  // inst_valid && inst_ready. Credit counts buffered entries plus live
  // in-flight requests so every kept response is guaranteed a FIFO slot.
  assign w_credit      = CRW'(w_fifo_count) + CRW'(r_inflight) - CRW'(r_discard);
  assign mem_req_valid = (r_state == ST_RUN) && !redirect_valid &&
                         (r_inflight < IW'(MAX_OUTSTANDING)) &&
                         (w_credit < CRW'(FIFO_DEPTH));
  assign mem_req_addr  = {r_fetch_pc[XLEN-1:3], 3'b000};
  assign w_req_hs      = mem_req_valid && mem_req_ready;

  assign w_resp_keep   = mem_resp_valid && !redirect_valid && (r_discard == '0);
  assign w_half        = w_pcq_head[2] ? mem_resp_data[XLEN-1:XLEN/2]
                                       : mem_resp_data[XLEN/2-1:0];
  assign w_fifo_push   = w_resp_keep;
  assign w_fifo_wdata  = {mem_resp_err, w_pcq_head,
                          mem_resp_err ? {ILEN{1'b0}} : ILEN'(w_half)};
  assign w_fifo_pop    = inst_valid && inst_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT:  w_state_nxt = ST_RUN;
      ST_RUN:   if (w_resp_keep && mem_resp_err) w_state_nxt = ST_STALL;
      ST_STALL: if (redirect_valid) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_BOOT;
      r_fetch_pc <= RESET_PC;
      r_inflight <= '0;
      r_discard  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= r_inflight + IW'(w_req_hs) - IW'(mem_resp_valid);
      if (redirect_valid) begin
        // Everything still in flight, minus a response landing now, is stale.
        r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        r_discard  <= r_inflight - IW'(mem_resp_valid);
      end else begin
        if (w_req_hs) r_fetch_pc <= r_fetch_pc + XLEN'(4);
        if (mem_resp_valid && (r_discard != '0)) r_discard <= r_discard - 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (redirect_valid),
    .push      (w_req_hs),
    .push_data (r_fetch_pc),
    .pop       (w_resp_keep),
    .pop_data  (w_pcq_head),
    .full      (w_pcq_full),
    .empty     (w_pcq_empty),
    .count     (w_pcq_count)
  );

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_inst_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (redirect_valid),
    .push      (w_fifo_push),
    .push_data (w_fifo_wdata),
    .pop       (w_fifo_pop),
    .pop_data  (w_fifo_rdata),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  assign inst_valid = !w_fifo_empty;
  assign {inst_err, inst_pc, inst_data} = w_fifo_rdata;
  assign busy       = (r_inflight != '0);
  assign dbg_state  = r_state;

  a_inflight_max: assert property (@(posedge clk) disable iff (!rst_n)
    r_inflight <= IW'(MAX_OUTSTANDING));
  a_discard_le: assert property (@(posedge clk) disable iff (!rst_n)
    r_discard <= r_inflight);
  a_resp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    mem_resp_valid |-> (r_inflight != '0));
  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_fifo_push && w_fifo_full && !w_fifo_pop));
  a_pcq_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_req_hs && w_pcq_full));
  a_pcq_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_resp_keep && w_pcq_empty));
  a_pcq_tracks_live: assert property (@(posedge clk) disable iff (!rst_n)
    w_pcq_count == (r_inflight - r_discard));

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: in-order latency memory model, transaction-level
// instruction scoreboard, directed scenarios and a randomized phase.
module tb_ifu_prefetch;
  import ifu_prefetch_pkg::*;

  localparam int          XLEN     = 64;
  localparam int          ILEN     = 32;
  localparam int          MAX_OUT  = 2;
  localparam int          EW       = 1 + XLEN + ILEN;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic            clk;
  logic            rst_n;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_data;
  logic            mem_resp_err;
  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            inst_err;
  logic            busy;
  state_e          dbg_state;

  ifu_prefetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_err   (mem_resp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_err       (inst_err),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  // ---------------- model state ----------------
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  int              req_cnt = 0;
  int              del_cnt = 0;
  int              mem_lat = 1;
  logic [XLEN-1:0] mq_addr[$];
  int              mq_due[$];
  logic [EW-1:0]   exp_q[$];
  logic [EW-1:0]   last_del;
  logic [XLEN-1:0] exp_req_pc;
  logic [XLEN-1:0] err_addr;
  logic            drv_redirect;
  logic [XLEN-1:0] drv_redirect_pc;
  logic            drv_inst_ready;
  logic            drv_mem_ready;
  logic            arm_redirect_on_resp;

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h0010_0093_0000_0013;
    return {a[31:0] ^ 32'hC3A5_0004, a[31:0] ^ 32'h5A5A_1000};
  endfunction

  // Each accepted request since the last redirect yields one entry, in order.
  function automatic logic [EW-1:0] exp_entry(input logic [63:0] pc);
    logic [63:0] w;
    logic        e;
    logic [31:0] d;
    w = mem_word({pc[63:3], 3'b000});
    e = ({pc[63:3], 3'b000} == err_addr);
    d = e ? 32'h0 : (pc[2] ? w[63:32] : w[31:0]);
    return {e, pc, d};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    logic [63:0] a;
    logic        resp_now;
    @(negedge clk);
    cyc++;
    resp_now = 1'b0;
    if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
      a = mq_addr.pop_front();
      void'(mq_due.pop_front());
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_word(a);
      mem_resp_err   = (a == err_addr);
      resp_now       = 1'b1;
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = {$urandom, $urandom};
      mem_resp_err   = 1'($urandom_range(0, 1));
    end
    redirect_valid = drv_redirect || (arm_redirect_on_resp && resp_now);
    if (resp_now) arm_redirect_on_resp = 1'b0;
    redirect_pc    = drv_redirect_pc;
    inst_ready     = drv_inst_ready;
    mem_req_ready  = drv_mem_ready;
    drv_redirect   = 1'b0;
    #1;
    chk("busy", busy, 128'((mq_addr.size() + int'(resp_now)) != 0));
    if (redirect_valid) chk("no_req_on_redirect", mem_req_valid, 1'b0);
    if (mem_req_valid) chk("req_addr", mem_req_addr, {exp_req_pc[63:3], 3'b000});
    if (inst_valid && inst_ready && !redirect_valid) begin
      chk("inst_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        last_del = {inst_err, inst_pc, inst_data};
        chk("inst_entry", last_del, exp_q.pop_front());
        del_cnt++;
      end
    end
    if (mem_req_valid && mem_req_ready) begin
      mq_addr.push_back(mem_req_addr);
      mq_due.push_back(cyc + mem_lat);
      exp_q.push_back(exp_entry(exp_req_pc));
      exp_req_pc += 64'd4;
      req_cnt++;
      chk("outstanding_max", mq_addr.size() <= MAX_OUT, 1'b1);
    end
    if (redirect_valid) begin
      exp_q.delete();
      exp_req_pc = {redirect_pc[63:2], 2'b00};
    end
  endtask

  task automatic do_reset();
    rst_n                = 1'b0;
    redirect_valid       = 1'b0;
    redirect_pc          = '0;
    mem_req_ready        = 1'b0;
    mem_resp_valid       = 1'b0;
    mem_resp_data        = '0;
    mem_resp_err         = 1'b0;
    inst_ready           = 1'b0;
    mq_addr.delete();
    mq_due.delete();
    exp_q.delete();
    drv_redirect         = 1'b0;
    drv_redirect_pc      = '0;
    drv_inst_ready       = 1'b1;
    drv_mem_ready        = 1'b1;
    arm_redirect_on_resp = 1'b0;
    mem_lat              = 1;
    err_addr             = '1;
    req_cnt              = 0;
    del_cnt              = 0;
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    exp_req_pc = RESET_PC;
    #1;
    chk("boot_no_req", mem_req_valid, 1'b0);
    chk("boot_state", dbg_state, ST_BOOT);
  endtask

  task automatic wait_del(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (del_cnt < n && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_wait"}, del_cnt >= n, 1'b1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int          c0;
    int          d0;
    int          k;
    logic [63:0] w;

    // Zero-wait memory: order, contents, first latency, throughput.
    do_reset();
    c0 = cyc;
    wait_del("zw_first", 1, 10);
    chk("zw_first_latency", cyc - c0, 3);
    chk("zw_first_entry", last_del, {1'b0, 64'h8000_0000, 32'h0000_0013});
    wait_del("zw_second", 2, 5);
    chk("zw_second_entry", last_del, {1'b0, 64'h8000_0004, 32'h0010_0093});
    wait_del("zw_third", 3, 5);
    chk("zw_third_pc", last_del[ILEN +: XLEN], 64'h8000_0008);
    d0 = del_cnt;
    repeat (20) step();
    chk("zw_throughput", del_cnt - d0, 20);

    // Decode stalled: credit limits requests to the FIFO depth.
    do_reset();
    drv_inst_ready = 1'b0;
    repeat (20) step();
    chk("bp_req_count", req_cnt, 4);
    chk("bp_req_valid", mem_req_valid, 1'b0);
    chk("bp_busy", busy, 1'b0);
    chk("bp_inst_valid", inst_valid, 1'b1);
    chk("bp_head_pc", inst_pc, RESET_PC);
    drv_inst_ready = 1'b1;
    d0 = del_cnt;
    repeat (4) step();
    chk("bp_drain_count", del_cnt - d0, 4);
    chk("bp_drain_last_pc", last_del[ILEN +: XLEN], RESET_PC + 64'd12);

    // Redirect with two requests in flight, latency 3.
    do_reset();
    mem_lat = 3;
    k = 0;
    while (mq_addr.size() < 2 && k < 10) begin step(); k++; end
    chk("rd_two_inflight", mq_addr.size(), 2);
    drv_redirect    = 1'b1;
    drv_redirect_pc = 64'h8000_0103;
    step();
    wait_del("rd_next", del_cnt + 1, 30);
    w = mem_word(64'h8000_0100);
    chk("rd_next_pc", last_del[ILEN +: XLEN], 64'h8000_0100);
    chk("rd_next_data", last_del[ILEN-1:0], w[31:0]);

    // Redirect coinciding with a response while the FIFO is at credit limit.
    do_reset();
    drv_inst_ready = 1'b0;
    k = 0;
    while (req_cnt < 4 && k < 10) begin step(); k++; end
    chk("rr_req_count", req_cnt, 4);
    arm_redirect_on_resp = 1'b1;
    drv_redirect_pc      = 64'h8000_0300;
    step();
    chk("rr_redirect_fired", redirect_valid, 1'b1);
    chk("rr_resp_same_cycle", mem_resp_valid, 1'b1);
    step();
    chk("rr_fifo_empty", inst_valid, 1'b0);
    drv_inst_ready = 1'b1;
    wait_del("rr_next", del_cnt + 1, 20);
    chk("rr_next_pc", last_del[ILEN +: XLEN], 64'h8000_0300);

    // Bus error: faulting entry, then stall until redirect.
    do_reset();
    err_addr = 64'h8000_0008;
    k = 0;
    while (!(del_cnt > 0 && last_del[EW-1]) && k < 30) begin step(); k++; end
    chk("err_seen", del_cnt > 0 && last_del[EW-1], 1'b1);
    chk("err_pc", last_del[ILEN +: XLEN], 64'h8000_0008);
    chk("err_data", last_del[ILEN-1:0], 32'h0);
    repeat (8) step();
    chk("err_stall_state", dbg_state, ST_STALL);
    chk("err_stall_no_req", mem_req_valid, 1'b0);
    chk("err_stall_idle", busy, 1'b0);
    err_addr        = '1;
    drv_redirect    = 1'b1;
    drv_redirect_pc = 64'h8000_0200;
    step();
    wait_del("err_resume", del_cnt + 1, 20);
    chk("err_resume_entry", last_del[EW-1 -: 1+XLEN], {1'b0, 64'h8000_0200});

    // Reset mid-stream with two requests in flight.
    do_reset();
    mem_lat = 3;
    k = 0;
    while (mq_addr.size() < 2 && k < 10) begin step(); k++; end
    chk("rst_two_inflight", mq_addr.size(), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_req_valid", mem_req_valid, 1'b0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst_err", inst_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_inst_pc", inst_pc, 64'h0);
    do_reset();
    step();
    chk("rst_first_req_valid", mem_req_valid, 1'b1);
    chk("rst_first_req_addr", mem_req_addr, RESET_PC);

    // Randomized traffic against the scoreboard.
    do_reset();
    mem_lat = $urandom_range(1, 4);
    for (int i = 0; i < 400; i++) begin
      drv_mem_ready  = ($urandom_range(0, 3) != 0);
      drv_inst_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        drv_redirect    = 1'b1;
        drv_redirect_pc = {$urandom, $urandom};
      end
      step();
    end
    drv_mem_ready  = 1'b1;
    drv_inst_ready = 1'b0;
    repeat (20) step();
    chk("rnd_fill_entries", exp_q.size(), 4);
    chk("rnd_fill_idle", busy, 1'b0);
    drv_mem_ready  = 1'b0;
    drv_inst_ready = 1'b1;
    repeat (10) step();
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_empty", inst_valid, 1'b0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
